// File: rtl/rect_fill_if.sv
// Command and frame-buffer write-port bundle for the rectangle fill engine.
// master = sequencer side, slave = fill engine.
interface rect_fill_if;
    logic       start;
    logic [9:0] x0;
    logic [9:0] y0;
    logic [9:0] x1;
    logic [9:0] y1;
    logic [7:0] color_r;
    logic [7:0] color_g;
    logic [7:0] color_b;
    logic       swap_after;
    logic       stall;

    logic [9:0] position_x_new;
    logic [9:0] position_y_new;
    logic [7:0] color_r_new;
    logic [7:0] color_g_new;
    logic [7:0] color_b_new;
    logic       wr_en;
    logic       swap;
    logic       busy;
    logic       done;

    modport master (
        output start, x0, y0, x1, y1, color_r, color_g, color_b, swap_after, stall,
        input  position_x_new, position_y_new, color_r_new, color_g_new, color_b_new,
               wr_en, swap, busy, done
    );

    modport slave (
        input  start, x0, y0, x1, y1, color_r, color_g, color_b, swap_after, stall,
        output position_x_new, position_y_new, color_r_new, color_g_new, color_b_new,
               wr_en, swap, busy, done
    );
endinterface

// File: rtl/rect_fill_engine.sv
// Back-buffer rectangle filler: one solid-colour pixel per clock in raster order,
// with an optional buffer-swap pulse once the last pixel has been written.
module rect_fill_engine #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        clear,
    rect_fill_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SWAP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [9:0] X_LIM = 10'(H_RES - 1);
    localparam logic [9:0] Y_LIM = 10'(V_RES - 1);

    state_t     state;
    state_t     state_n;

    logic [9:0] xmin;
    logic [9:0] xmax;
    logic [9:0] ymin;
    logic [9:0] ymax;
    logic [9:0] cx;
    logic [9:0] cy;
    logic [7:0] fill_r;
    logic [7:0] fill_g;
    logic [7:0] fill_b;
    logic       fill_swap;

    logic       row_end;
    logic       last_px;
    logic       advance;

    logic [9:0] pos_x_q;
    logic [9:0] pos_y_q;
    logic [7:0] col_r_q;
    logic [7:0] col_g_q;
    logic [7:0] col_b_q;
    logic       wr_en_q;
    logic       swap_q;
    logic       busy_q;
    logic       done_q;

    logic [9:0] pos_x_n;
    logic [9:0] pos_y_n;
    logic [7:0] col_r_n;
    logic [7:0] col_g_n;
    logic [7:0] col_b_n;
    logic       wr_en_n;
    logic       swap_n;
    logic       busy_n;
    logic       done_n;

    function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [9:0] max10(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? a : b;
    endfunction

    assign row_end = (cx == xmax);
    assign last_px = row_end && (cy == ymax);
    assign advance = (state == FILL) && !bus.stall;

    // State register
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.start) state_n = FILL;
            FILL: if (advance && last_px) state_n = fill_swap ? SWAP : DONE;
            SWAP: state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Rectangle bounds and raster counters; only meaningful outside IDLE, so no reset
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            xmin      <= clamp(min10(bus.x0, bus.x1), X_LIM);
            xmax      <= clamp(max10(bus.x0, bus.x1), X_LIM);
            ymin      <= clamp(min10(bus.y0, bus.y1), Y_LIM);
            ymax      <= clamp(max10(bus.y0, bus.y1), Y_LIM);
            cx        <= clamp(min10(bus.x0, bus.x1), X_LIM);
            cy        <= clamp(min10(bus.y0, bus.y1), Y_LIM);
            fill_r    <= bus.color_r;
            fill_g    <= bus.color_g;
            fill_b    <= bus.color_b;
            fill_swap <= bus.swap_after;
        end else if (advance) begin
            if (row_end) begin
                cx <= xmin;
                cy <= cy + 10'd1;
            end else begin
                cx <= cx + 10'd1;
            end
        end
    end

    // Output next values; position/colour hold their last value when no write is issued
    always_comb begin
        pos_x_n = pos_x_q;
        pos_y_n = pos_y_q;
        col_r_n = col_r_q;
        col_g_n = col_g_q;
        col_b_n = col_b_q;
        wr_en_n = 1'b0;
        swap_n  = 1'b0;
        done_n  = 1'b0;
        // busy stays up through the cycle in which done is shown
        busy_n  = (state_n != IDLE) || (state == DONE);
        if (advance) begin
            pos_x_n = cx;
            pos_y_n = cy;
            col_r_n = fill_r;
            col_g_n = fill_g;
            col_b_n = fill_b;
            wr_en_n = 1'b1;
        end
        if (state == SWAP) swap_n = 1'b1;
        if (state == DONE) done_n = 1'b1;
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (clear) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
            col_r_q <= '0;
            col_g_q <= '0;
            col_b_q <= '0;
            wr_en_q <= 1'b0;
            swap_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pos_x_q <= pos_x_n;
            pos_y_q <= pos_y_n;
            col_r_q <= col_r_n;
            col_g_q <= col_g_n;
            col_b_q <= col_b_n;
            wr_en_q <= wr_en_n;
            swap_q  <= swap_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bus.position_x_new = pos_x_q;
    assign bus.position_y_new = pos_y_q;
    assign bus.color_r_new    = col_r_q;
    assign bus.color_g_new    = col_g_q;
    assign bus.color_b_new    = col_b_q;
    assign bus.wr_en          = wr_en_q;
    assign bus.swap           = swap_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed and randomized bench for rect_fill_engine against a pixel-list model
// of the rectangle built from clamped corner coordinates.
module tb_rect_fill_engine;

    logic clk;
    logic clear;
    int   total;
    int   bad;

    rect_fill_if bus ();

    rect_fill_engine #(.H_RES(640), .V_RES(480)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clip(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_x"},    32'(bus.position_x_new), 0);
        check({tag, "_y"},    32'(bus.position_y_new), 0);
        check({tag, "_r"},    32'(bus.color_r_new), 0);
        check({tag, "_g"},    32'(bus.color_g_new), 0);
        check({tag, "_b"},    32'(bus.color_b_new), 0);
        check({tag, "_wr"},   32'(bus.wr_en), 0);
        check({tag, "_swap"}, 32'(bus.swap), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
    endtask

    // stall_mode: 0 never, 1 alternate cycles, 2 random ~30%
    task automatic run_fill(input string tag, input int ax0, input int ay0, input int ax1, input int ay1,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic sw, input int stall_mode);
        int qx[$];
        int qy[$];
        int xlo, xhi, ylo, yhi, npix, nw, fstall, iter, last_iter, swap_iter, done_iter, busy_cnt;
        logic st;
        xlo = clip((ax0 < ax1) ? ax0 : ax1, 639);
        xhi = clip((ax0 > ax1) ? ax0 : ax1, 639);
        ylo = clip((ay0 < ay1) ? ay0 : ay1, 479);
        yhi = clip((ay0 > ay1) ? ay0 : ay1, 479);
        for (int y = ylo; y <= yhi; y++)
            for (int x = xlo; x <= xhi; x++) begin
                qx.push_back(x);
                qy.push_back(y);
            end
        npix = qx.size();

        bus.x0 = 10'(ax0); bus.y0 = 10'(ay0); bus.x1 = 10'(ax1); bus.y1 = 10'(ay1);
        bus.color_r = r; bus.color_g = g; bus.color_b = b;
        bus.swap_after = sw; bus.stall = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.x0 = 10'($urandom); bus.y0 = 10'($urandom); bus.x1 = 10'($urandom); bus.y1 = 10'($urandom);
        bus.color_r = 8'($urandom); bus.color_g = 8'($urandom); bus.color_b = 8'($urandom);
        bus.swap_after = ~sw;
        check({tag, "_first_wr_latency"}, 32'(bus.wr_en), 0);
        check({tag, "_busy_after_start"}, 32'(bus.busy), 1);
        busy_cnt = bus.busy ? 1 : 0;

        nw = 0; fstall = 0; iter = 0; last_iter = -1; swap_iter = -1; done_iter = -1;
        while (done_iter < 0 && iter < 4000) begin
            case (stall_mode)
                1: st = iter[0];
                2: st = ($urandom_range(0, 99) < 30);
                default: st = 1'b0;
            endcase
            bus.stall = st;
            if (st && nw < npix) fstall++;
            tick();
            iter++;
            if (bus.busy) busy_cnt++;
            if (st) check({tag, "_wr_on_stall"}, 32'(bus.wr_en), 0);
            if (bus.wr_en) begin
                if (qx.size() == 0) begin
                    check({tag, "_extra_write"}, 1, 0);
                end else begin
                    check({tag, "_px"}, 32'(bus.position_x_new), 32'(qx.pop_front()));
                    check({tag, "_py"}, 32'(bus.position_y_new), 32'(qy.pop_front()));
                    check({tag, "_rgb"}, {8'h0, bus.color_r_new, bus.color_g_new, bus.color_b_new},
                          {8'h0, r, g, b});
                    nw++;
                    last_iter = iter;
                end
            end
            if (bus.swap) swap_iter = iter;
            if (bus.done) done_iter = iter;
        end
        bus.stall = 1'b0;
        check({tag, "_timeout"}, 32'(done_iter >= 0), 1);
        check({tag, "_n_writes"}, 32'(nw), 32'(npix));
        check({tag, "_swap_pos"}, 32'(swap_iter), sw ? 32'(last_iter + 1) : 32'hFFFF_FFFF);
        check({tag, "_done_pos"}, 32'(done_iter), 32'(last_iter + 1 + (sw ? 1 : 0)));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(npix + fstall + (sw ? 1 : 0) + 2));
        tick();
        check({tag, "_done_1cyc"}, 32'(bus.done), 0);
        check({tag, "_busy_end"}, 32'(bus.busy), 0);
        check({tag, "_wr_end"}, 32'(bus.wr_en), 0);
        check({tag, "_swap_end"}, 32'(bus.swap), 0);
    endtask

    initial begin
        int nw;
        int rx0, ry0, rx1, ry1;
        int qx[$];
        int qy[$];
        total = 0;
        bad = 0;
        bus.start = 1'b0; bus.stall = 1'b0; bus.swap_after = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        bus.color_r = '0; bus.color_g = '0; bus.color_b = '0;

        clear = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        clear = 1'b0;
        tick();

        run_fill("single", 5, 7, 5, 7, 8'hFF, 8'h00, 8'h80, 1'b0, 0);
        run_fill("swapped", 12, 11, 10, 10, 8'h12, 8'h34, 8'h56, 1'b1, 0);
        run_fill("stall_alt", 0, 0, 3, 0, 8'hA5, 8'h5A, 8'h3C, 1'b0, 1);
        run_fill("clamp", 630, 478, 1000, 900, 8'h01, 8'h02, 8'h03, 1'b1, 2);

        for (int t = 0; t < 6; t++) begin
            rx0 = $urandom_range(0, 1023);
            ry0 = $urandom_range(0, 1023);
            rx1 = rx0 + $urandom_range(0, 12) - 6;
            ry1 = ry0 + $urandom_range(0, 8) - 4;
            if (rx1 < 0) rx1 = 0;
            if (rx1 > 1023) rx1 = 1023;
            if (ry1 < 0) ry1 = 0;
            if (ry1 > 1023) ry1 = 1023;
            run_fill("rand", rx0, ry0, rx1, ry1, 8'($urandom), 8'($urandom), 8'($urandom),
                     1'($urandom), 2);
        end

        // Abort a 10x10 fill after its third write; a mid-fill start must not disturb it
        for (int y = 200; y <= 209; y++)
            for (int x = 100; x <= 109; x++) begin
                qx.push_back(x);
                qy.push_back(y);
            end
        bus.x0 = 10'd100; bus.y0 = 10'd200; bus.x1 = 10'd109; bus.y1 = 10'd209;
        bus.color_r = 8'h77; bus.color_g = 8'h88; bus.color_b = 8'h99;
        bus.swap_after = 1'b1; bus.stall = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        nw = 0;
        for (int i = 0; i < 20 && nw < 3; i++) begin
            bus.start = (nw == 1);
            if (bus.start) begin
                bus.x0 = 10'd1; bus.y0 = 10'd1; bus.x1 = 10'd2; bus.y1 = 10'd2;
            end
            tick();
            bus.start = 1'b0;
            if (bus.wr_en) begin
                check("abort_px", 32'(bus.position_x_new), 32'(qx.pop_front()));
                check("abort_py", 32'(bus.position_y_new), 32'(qy.pop_front()));
                nw++;
            end
        end
        check("abort_three_writes", 32'(nw), 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_idle_outputs("abort");
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_quiet", {28'h0, bus.wr_en, bus.swap, bus.done, bus.busy}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
